// File: rtl/qr_pkg.sv
// Shared definitions for the QR (Gram-Schmidt) datapath stages.
package qr_pkg;

  localparam int QR_DATA_W   = 16;
  localparam int NORM_FRAC_W = 8;
  localparam int Q_FRAC_W    = 15;

  typedef enum logic [1:0] {
    eIDLE,
    eWAIT_A,
    eDIV,
    eOUT
  } col_state_e;

endpackage

// File: rtl/col_normalize_udiv_seq.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first, with a
// saturating quotient output.
module udiv_seq #(
  parameter int DVD_W = 39,
  parameter int DVS_W = 16,
  parameter int Q_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [Q_W-1:0]   quot_o
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [DVS_W:0]   rem_sh;
  logic [DVS_W:0]   rem_sub;
  logic             ge;
  logic             rem_unused;

  function automatic logic [Q_W-1:0] sat_quot(input logic [DVD_W-1:0] q);
    return (|q[DVD_W-1:Q_W]) ? {Q_W{1'b1}} : q[Q_W-1:0];
  endfunction

  // Remainder stays below the divisor, so its top bit never feeds the shift.
  assign rem_sh     = {rem_q[DVS_W-1:0], dvd_q[DVD_W-1]};
  assign ge         = rem_sh >= {1'b0, dvs_q};
  assign rem_sub    = rem_sh - {1'b0, dvs_q};
  assign rem_unused = rem_q[DVS_W];

  assign done_o = busy_q && (cnt_q == CNT_W'(DVD_W - 1));
  assign quot_o = sat_quot(dvd_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      dvd_q  <= dividend_i;
      dvs_q  <= divisor_i;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      // Quotient bits shift in where dividend bits shift out.
      rem_q <= ge ? rem_sub : rem_sh;
      dvd_q <= {dvd_q[DVD_W-2:0], ge};
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/col_normalize.sv
// Column normalizer: q_i = a_i / ||a|| in unsigned Q1.15, one element at a
// time, with valid/yumi handshakes on norm, element and result.
module col_normalize
  import qr_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int DATA_W = QR_DATA_W,
  parameter int FRAC_W = Q_FRAC_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] norm_i,
  input  logic              norm_v_i,
  output logic              norm_yumi_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic              a_v_i,
  output logic              a_ready_o,
  output logic [DATA_W-1:0] q_o,
  output logic              v_o,
  input  logic              yumi_i,
  output logic              col_done_o,
  output logic              div0_o
);

  localparam int ITER  = DATA_W + NORM_FRAC_W + FRAC_W;
  localparam int CNT_W = $clog2(N_ROWS + 1);

  col_state_e state_q, state_d;

  logic [DATA_W-1:0] norm_q;
  logic [CNT_W-1:0]  row_q;
  logic              div0_q;
  logic [DATA_W-1:0] q_q;
  logic              v_q;

  logic              a_hs;
  logic              q_hs;
  logic              last_row;
  logic              div_start;
  logic              div_done;
  logic [DATA_W-1:0] div_q;
  logic [ITER-1:0]   dividend;

  assign norm_yumi_o = reset_n_i && (state_q == eIDLE) && norm_v_i;
  assign a_ready_o   = (state_q == eWAIT_A);
  assign a_hs        = a_ready_o && a_v_i;
  assign q_hs        = (state_q == eOUT) && v_q && yumi_i;
  assign last_row    = (row_q == CNT_W'(N_ROWS - 1));
  assign col_done_o  = q_hs && last_row;
  assign div_start   = a_hs && !div0_q;
  assign dividend    = {a_i, {(ITER - DATA_W){1'b0}}};

  assign q_o    = q_q;
  assign v_o    = v_q;
  assign div0_o = div0_q;

  udiv_seq #(
    .DVD_W(ITER),
    .DVS_W(DATA_W),
    .Q_W  (DATA_W)
  ) u_div (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (div_start),
    .dividend_i(dividend),
    .divisor_i (norm_q),
    .done_o    (div_done),
    .quot_o    (div_q)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= eIDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      eIDLE:   if (norm_v_i) state_d = eWAIT_A;
      eWAIT_A: if (a_v_i) state_d = eDIV;
      eDIV:    if (div0_q || div_done) state_d = eOUT;
      eOUT:    if (q_hs) state_d = last_row ? eIDLE : eWAIT_A;
      default: state_d = eIDLE;
    endcase
  end

  // The first eOUT cycle latches the result; v_o rises one edge later.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      norm_q <= '0;
      row_q  <= '0;
      div0_q <= 1'b0;
      q_q    <= '0;
      v_q    <= 1'b0;
    end else begin
      if ((state_q == eIDLE) && norm_v_i) begin
        norm_q <= norm_i;
        row_q  <= '0;
        div0_q <= (norm_i == '0);
      end
      if ((state_q == eOUT) && !v_q) begin
        v_q <= 1'b1;
        q_q <= div0_q ? '0 : div_q;
      end
      if (q_hs) begin
        v_q   <= 1'b0;
        row_q <= row_q + 1'b1;
        if (last_row) div0_q <= 1'b0;
      end
    end
  end

endmodule
